// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-way WIDTH-bit select mux feeding a STAGES-deep register pipeline with valid, stall and flush.
// Defining PIPE_MUX_SELERR_EN adds a sticky sel_err flag for out-of-range selects.
module pipe_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int STAGES = 1,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
`ifdef PIPE_MUX_SELERR_EN
    output logic                    out_valid,
    output logic                    sel_err
`else
    output logic                    out_valid
`endif
);

    // The word table is padded to a power of two so any sel value indexes it; unused slots read as zero.
    localparam int NUM_PAD = 32'd1 << SEL_W;

    logic [WIDTH-1:0] in_word_s [NUM_PAD];
    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] data_r    [STAGES];
    logic             valid_r   [STAGES];

    for (genvar i = 0; i < NUM_PAD; i++) begin : g_word
        if (i < NUM_IN) begin : g_live
            assign in_word_s[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign in_word_s[i] = '0;
        end
    end

    assign mux_s = in_word_s[sel];

    // Pipeline registers: reset, then flush, then stall, then advance; bubbles always carry zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                data_r[k]  <= '0;
                valid_r[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                data_r[k]  <= '0;
                valid_r[k] <= 1'b0;
            end
        end else if (stall) begin
            for (int k = 0; k < STAGES; k++) begin
                data_r[k]  <= data_r[k];
                valid_r[k] <= valid_r[k];
            end
        end else begin
            data_r[0]  <= in_valid ? mux_s : '0;
            valid_r[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                data_r[k]  <= data_r[k-1];
                valid_r[k] <= valid_r[k-1];
            end
        end
    end

    assign out       = data_r[STAGES-1];
    assign out_valid = valid_r[STAGES-1];

`ifdef PIPE_MUX_SELERR_EN
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

    logic sel_oor_s;
    logic sel_err_r;

    assign sel_oor_s = ({1'b0, sel} >= NUM_IN_L);

    // Sticky flag: set only by an accepted out-of-range sample, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (!stall && !flush && in_valid && sel_oor_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    assign sel_err = sel_err_r;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed self-checking bench driving four pipe_mux_n configurations from shared stimulus.
// Checks sel_err only when PIPE_MUX_SELERR_EN is defined.
module tb_pipe_mux_n;

    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'hBBBB_0001;
    localparam logic [31:0] W2 = 32'hCCCC_0002;
    localparam logic [31:0] W3 = 32'hDDDD_0003;
    localparam logic [32:0] BUBBLE = 33'h0_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         stall;
    logic         flush;
    logic [1:0]   sel;
    logic [127:0] in_data4;
    logic [95:0]  in_data3;

    logic [31:0] out1, out2, out3, out_n3;
    logic        ov1, ov2, ov3, ov_n3;
`ifdef PIPE_MUX_SELERR_EN
    logic        se1, se2, se3, se_n3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign in_data4 = {W3, W2, W1, W0};
    assign in_data3 = {W2, W1, W0};

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out1),
`ifdef PIPE_MUX_SELERR_EN
        .out_valid(ov1), .sel_err(se1)
`else
        .out_valid(ov1)
`endif
    );

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .STAGES(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out2),
`ifdef PIPE_MUX_SELERR_EN
        .out_valid(ov2), .sel_err(se2)
`else
        .out_valid(ov2)
`endif
    );

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .STAGES(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out3),
`ifdef PIPE_MUX_SELERR_EN
        .out_valid(ov3), .sel_err(se3)
`else
        .out_valid(ov3)
`endif
    );

    pipe_mux_n #(.WIDTH(32), .NUM_IN(3), .STAGES(1)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out_n3),
`ifdef PIPE_MUX_SELERR_EN
        .out_valid(ov_n3), .sel_err(se_n3)
`else
        .out_valid(ov_n3)
`endif
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic st, input logic fl);
        in_valid = v;
        sel      = s;
        stall    = st;
        flush    = fl;
    endtask

    // Streaming vectors for the 3-stage instance: inputs per edge and expected output after edge i (i>=2).
    logic        st_v   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  st_s   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2};
    logic [32:0] st_exp [6] = '{{1'b1, W0}, {1'b1, W1}, {1'b1, W2}, {1'b1, W3}, BUBBLE, {1'b1, W0}};

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_value("reset_s1", {ov1, out1}, BUBBLE);
        check_value("reset_s3", {ov3, out3}, BUBBLE);
`ifdef PIPE_MUX_SELERR_EN
        check_value("reset_selerr", {63'd0, se_n3}, 64'd0);
`endif

        // Basic select
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_value("basic_sel2", {ov1, out1}, {1'b1, W2});
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        check_value("basic_sel0", {ov1, out1}, {1'b1, W0});
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        check_value("flush_clear_s3", {ov3, out3}, BUBBLE);

        // Latency and streaming
        for (int i = 0; i < 8; i++) begin
            drive(st_v[i], st_s[i], 1'b0, 1'b0);
            tick();
            if (i >= 2) check_value("stream_s3", {ov3, out3}, st_exp[i-2]);
            if (i == 4) check_value("stream_s1_bubble", {ov1, out1}, BUBBLE);
            if (i == 5) check_value("stream_s2_bubble", {ov2, out2}, BUBBLE);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        tick();

        // Stall
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_value("stall_pre_s2", {ov2, out2}, {1'b1, W1});
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 1'b1, 1'b0);
            tick();
            check_value("stall_hold_s2", {ov2, out2}, {1'b1, W1});
            if (i == 0) check_value("stall_hold_s1", {ov1, out1}, {1'b1, W2});
        end
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        check_value("stall_release_s2", {ov2, out2}, {1'b1, W2});
        tick();
        check_value("stall_dropped_s2", {ov2, out2}, BUBBLE);

        // Flush beats stall
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_value("flush_full_s3", {ov3, out3}, {1'b1, W0});
        drive(1'b1, 2'd3, 1'b1, 1'b1);
        tick();
        check_value("flush_stall_s3_0", {ov3, out3}, BUBBLE);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        check_value("flush_stall_s3_1", {ov3, out3}, BUBBLE);
        tick();
        check_value("flush_stall_s3_2", {ov3, out3}, BUBBLE);

        // Reset mid-stream
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_value("rst_pre_s1", {ov1, out1}, {1'b1, W2});
        rst_n = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        check_value("rst_mid_s1", {ov1, out1}, BUBBLE);
        check_value("rst_mid_s2", {ov2, out2}, BUBBLE);
        check_value("rst_mid_s3", {ov3, out3}, BUBBLE);
        rst_n = 1'b1;
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        check_value("rst_not_captured_s1", {ov1, out1}, BUBBLE);

        // Out-of-range select on the 3-input instance
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        tick();
`ifdef PIPE_MUX_SELERR_EN
        check_value("selerr_stalled", {63'd0, se_n3}, 64'd0);
`endif
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        tick();
`ifdef PIPE_MUX_SELERR_EN
        check_value("selerr_invalid", {63'd0, se_n3}, 64'd0);
`endif
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        check_value("oor_n3", {ov_n3, out_n3}, {1'b1, 32'h0000_0000});
        check_value("sel3_s1", {ov1, out1}, {1'b1, W3});
`ifdef PIPE_MUX_SELERR_EN
        check_value("selerr_set", {63'd0, se_n3}, 64'd1);
        check_value("selerr_pow2", {63'd0, se1}, 64'd0);
`endif
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        check_value("inrange_n3", {ov_n3, out_n3}, {1'b1, W2});
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        check_value("flush_n3", {ov_n3, out_n3}, BUBBLE);
`ifdef PIPE_MUX_SELERR_EN
        check_value("selerr_after_flush", {63'd0, se_n3}, 64'd1);
`endif
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        check_value("rst_n3", {ov_n3, out_n3}, BUBBLE);
`ifdef PIPE_MUX_SELERR_EN
        check_value("selerr_after_rst", {63'd0, se_n3}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
